multicore_nios2_debug_scan_slave: RTL and testbench
===================================================

// Module: multicore_nios2_debug_scan_slave
// PURPOSE
//  Parametrised debug scan slave for the Nios II debug path: N_CH instruction channels, DR_W-bit data register.
//  Sits between the synchronised virtual-JTAG event strobes and the CPU debug/OCI logic, all on the system clock.
//  Captures per-channel status, shifts serial data LSB-first, checks scan length, and publishes jdo.
//  On a good update, pulses take_action/take_no_action for the selected channel.
// PARAMETERS
//  IR_W     2   instruction register width; channel index = ir value
//  N_CH     4   number of channels (N_CH <= 2**IR_W)
//  DR_W     38  data register / jdo width (>= 2)
//  ACT_BIT  35  sr bit selecting take_action (1) vs take_no_action (0) at update
// PORTS
//  clk             in   1          system clock
//  reset           in   1          asynchronous, active-high reset
//  vs_uir          in   1          update-IR strobe, 1 cycle
//  vs_cdr          in   1          capture-DR strobe, 1 cycle
//  vs_sdr          in   1          shift strobe, 1 cycle per bit
//  vs_udr          in   1          update-DR strobe, 1 cycle
//  ir_in           in   IR_W       instruction, sampled on vs_uir
//  tdi             in   1          serial data in, sampled on vs_sdr
//  status_in       in   IR_W       status returned on ir_out
//  cap_data        in   N_CH*DR_W  capture words; channel k = [k*DR_W +: DR_W]
//  tdo             out  1          serial data out = sr[0]
//  ir_out          out  IR_W       status_in registered on vs_uir
//  jdo             out  DR_W       last accepted data word
//  take_action     out  N_CH       1-cycle pulse, one-hot
//  take_no_action  out  N_CH       1-cycle pulse, one-hot
//  scan_err        out  1          sticky: update with bad length or in wrong state
//  busy            out  1          high in CAPTURED/SHIFT
// BEHAVIOUR
//  Reset: sr, jdo, ir_reg, ir_out = 0; take_* = 0; scan_err = 0; bitcnt = 0; state = IDLE.
//  Reset asserted mid-scan aborts the scan at once. No pulse is emitted.
//  FSM states: IDLE, CAPTURED, SHIFT, UPDATE.
//   IDLE     --vs_cdr--> CAPTURED
//   CAPTURED --vs_sdr--> SHIFT
//   CAPTURED --vs_udr--> IDLE
//   SHIFT    --vs_udr--> UPDATE
//   UPDATE   --(1 cycle)--> IDLE
//   CAPTURED or SHIFT --vs_cdr--> CAPTURED (recapture, bitcnt cleared)
//  Priority within one cycle: vs_uir > vs_udr > vs_cdr > vs_sdr.
//  Lower-priority strobes in the same cycle are ignored.
//  vs_uir, any state: ir_reg <= ir_in; ir_out <= status_in.
//   If CAPTURED/SHIFT, scan is aborted -> IDLE, no pulse, scan_err unchanged.
//  vs_cdr: sr <= cap_data[ir_reg*DR_W +: DR_W] if ir_reg < N_CH, else sr <= 0; bitcnt <= 0.
//  vs_sdr in CAPTURED/SHIFT: sr <= {tdi, sr[DR_W-1:1]}.
//   bitcnt++ saturates at DR_W+1; bitcnt width = clog2(DR_W+2).
//   vs_sdr in IDLE is ignored.
//  vs_udr in SHIFT:
//   bitcnt == DR_W -> UPDATE. In the UPDATE cycle jdo <= sr and the pulse is registered,
//    so jdo and the pulse are visible 1 cycle after vs_udr.
//    Pulse target is take_action[ir_reg] if sr[ACT_BIT], else take_no_action[ir_reg].
//    ir_reg >= N_CH: jdo updates, no pulse.
//   bitcnt != DR_W (short or long scan) -> scan_err <= 1; jdo unchanged; no pulse; -> IDLE.
//  vs_udr in IDLE: scan_err <= 1.
//  scan_err clears only on reset, or on vs_uir with ir_in == all-ones (clear command).
//  tdo = sr[0], combinational from the register.
//  busy = (state == CAPTURED || state == SHIFT).
// STRUCTURE
//  Shared include multicore_nios2_debug_defs.vh holds:
//   FSM state localparams (2-bit);
//   default IR_W/DR_W/ACT_BIT;
//   IR_CLR_ERR = {IR_W{1'b1}}.
//  Sub-module multicore_nios2_debug_scan_chain:
//   sr + saturating bitcnt, with capture/shift controls; exposes sr and len_ok.
//  Top level holds the FSM, ir/status registers, jdo, pulse decode and scan_err.
// TESTING
//  1. Good scan: IR=1, cap_data ch1=38'h2A_5555_AAAA, cdr, 38 sdr with tdi=bit k of 38'h08_0000_0001, udr
//     -> tdo streams 0x2A_5555_AAAA LSB-first; jdo=38'h08_0000_0001 at udr+1; take_action=4'b0010 for 1 cycle.
//  2. ACT_BIT=0 variant: same as 1 with tdi word 38'h00_0000_0001
//     -> take_no_action=4'b0010, take_action=0.
//  3. Short scan: 37 sdr then udr -> scan_err=1, jdo unchanged, no pulses. Long scan, 40 sdr -> same.
//  4. Collision: vs_udr and vs_cdr in the same cycle after 38 shifts -> update wins, pulse issued, state IDLE.
//     Then vs_uir mid-shift -> abort, ir_out=status_in, no pulse.
//  5. Reset asserted after 20 shifts -> all outputs 0 immediately; following full scan behaves as test 1.
//  6. IR=3 with N_CH=3: capture gives sr=0; good scan updates jdo with no pulse.
//     vs_uir with ir_in=2'b11 clears scan_err.

Source files
------------

// File: rtl/multicore_nios2_debug_scan_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multicore_nios2_debug_scan_slave_pkg
// Brief   : Shared defaults, scan FSM state encoding and clear-command helper.
// Revision: 1.0 - initial release
// ============================================================================
package multicore_nios2_debug_scan_slave_pkg;

   localparam int c_DEF_IR_W    = 2;
   localparam int c_DEF_N_CH    = 4;
   localparam int c_DEF_DR_W    = 38;
   localparam int c_DEF_ACT_BIT = 35;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURED = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_UPDATE   = 2'd3
   } scan_state_t;

   // An all-ones instruction doubles as the sticky-error clear command.
   function automatic bit is_clr_err(input logic [31:0] ir, input int ir_w);
      return (ir & ((32'd1 << ir_w) - 32'd1)) == ((32'd1 << ir_w) - 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicore_nios2_debug_scan_chain.sv
`default_nettype none
// ============================================================================
// Module  : multicore_nios2_debug_scan_chain
// Brief   : Data shift register with saturating bit counter and length check.
// Revision: 1.0 - initial release
// ============================================================================
module multicore_nios2_debug_scan_chain #(
   parameter int DR_W = 38
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_capture,
   input  logic [DR_W-1:0] i_cap_word,
   input  logic            i_shift,
   input  logic            i_tdi,
   output logic [DR_W-1:0] o_sr,
   output logic            o_len_ok
);

   localparam int                 c_CNT_W   = $clog2(DR_W + 2);
   localparam logic [c_CNT_W-1:0] c_CNT_LEN = c_CNT_W'(DR_W);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DR_W + 1);

   logic [DR_W-1:0]    r_sr;
   logic [c_CNT_W-1:0] r_bitcnt;

   // Saturating one past the legal length keeps long scans distinguishable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr     <= '0;
         r_bitcnt <= '0;
      end else if (i_capture) begin
         r_sr     <= i_cap_word;
         r_bitcnt <= '0;
      end else if (i_shift) begin
         r_sr <= {i_tdi, r_sr[DR_W-1:1]};
         if (r_bitcnt != c_CNT_MAX)
            r_bitcnt <= r_bitcnt + 1'b1;
      end
   end

   assign o_sr     = r_sr;
   assign o_len_ok = (r_bitcnt == c_CNT_LEN);

endmodule
`default_nettype wire

// File: rtl/multicore_nios2_debug_scan_slave.sv
`default_nettype none
// ============================================================================
// Module  : multicore_nios2_debug_scan_slave
// Brief   : Nios II debug scan slave: IR/status, scan FSM, jdo and action pulses.
// Revision: 1.0 - initial release
// ============================================================================
module multicore_nios2_debug_scan_slave
   import multicore_nios2_debug_scan_slave_pkg::*;
#(
   parameter int IR_W    = c_DEF_IR_W,
   parameter int N_CH    = c_DEF_N_CH,
   parameter int DR_W    = c_DEF_DR_W,
   parameter int ACT_BIT = c_DEF_ACT_BIT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vs_uir,
   input  logic                 vs_cdr,
   input  logic                 vs_sdr,
   input  logic                 vs_udr,
   input  logic [IR_W-1:0]      ir_in,
   input  logic                 tdi,
   input  logic [IR_W-1:0]      status_in,
   input  logic [N_CH*DR_W-1:0] cap_data,
   output logic                 tdo,
   output logic [IR_W-1:0]      ir_out,
   output logic [DR_W-1:0]      jdo,
   output logic [N_CH-1:0]      take_action,
   output logic [N_CH-1:0]      take_no_action,
   output logic                 scan_err,
   output logic                 busy
);

   scan_state_t     r_state;
   logic [IR_W-1:0] r_ir_reg;
   logic [IR_W-1:0] r_ir_out;
   logic [DR_W-1:0] r_jdo;
   logic [N_CH-1:0] r_take_action;
   logic [N_CH-1:0] r_take_no_action;
   logic            r_scan_err;

   logic            w_busy;
   logic            w_capture;
   logic            w_shift;
   logic            w_len_ok;
   logic            w_clr_err;
   logic [DR_W-1:0] w_sr;
   logic [DR_W-1:0] w_cap_word;
   logic [N_CH-1:0] w_ch_sel;

   assign w_busy    = (r_state == ST_CAPTURED) || (r_state == ST_SHIFT);
   assign w_clr_err = is_clr_err(32'(ir_in), IR_W);

   // Strobe priority uir > udr > cdr > sdr; an update cycle ignores capture.
   assign w_capture = vs_cdr & ~vs_uir & ~vs_udr & (r_state != ST_UPDATE);
   assign w_shift   = vs_sdr & ~vs_uir & ~vs_udr & ~vs_cdr & w_busy;

   always_comb begin
      w_cap_word = '0;
      w_ch_sel   = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (r_ir_reg == IR_W'(k)) begin
            w_cap_word  = cap_data[k*DR_W +: DR_W];
            w_ch_sel[k] = 1'b1;
         end
      end
   end

   multicore_nios2_debug_scan_chain #(
      .DR_W (DR_W)
   ) u_chain (
      .clk        (clk),
      .reset      (reset),
      .i_capture  (w_capture),
      .i_cap_word (w_cap_word),
      .i_shift    (w_shift),
      .i_tdi      (tdi),
      .o_sr       (w_sr),
      .o_len_ok   (w_len_ok)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_ir_reg         <= '0;
         r_ir_out         <= '0;
         r_jdo            <= '0;
         r_take_action    <= '0;
         r_take_no_action <= '0;
         r_scan_err       <= 1'b0;
      end else begin
         r_take_action    <= '0;
         r_take_no_action <= '0;
         if (vs_uir) begin
            r_ir_reg <= ir_in;
            r_ir_out <= status_in;
            r_state  <= ST_IDLE;
            if (w_clr_err)
               r_scan_err <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (vs_udr)
                     r_scan_err <= 1'b1;
                  else if (vs_cdr)
                     r_state <= ST_CAPTURED;
               end
               ST_CAPTURED: begin
                  if (vs_udr) begin
                     r_scan_err <= 1'b1;
                     r_state    <= ST_IDLE;
                  end else if (vs_cdr)
                     r_state <= ST_CAPTURED;
                  else if (vs_sdr)
                     r_state <= ST_SHIFT;
               end
               ST_SHIFT: begin
                  if (vs_udr) begin
                     if (w_len_ok) begin
                        r_state <= ST_UPDATE;
                        r_jdo   <= w_sr;
                        if (w_sr[ACT_BIT])
                           r_take_action <= w_ch_sel;
                        else
                           r_take_no_action <= w_ch_sel;
                     end else begin
                        r_scan_err <= 1'b1;
                        r_state    <= ST_IDLE;
                     end
                  end else if (vs_cdr)
                     r_state <= ST_CAPTURED;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign tdo            = w_sr[0];
   assign ir_out         = r_ir_out;
   assign jdo            = r_jdo;
   assign take_action    = r_take_action;
   assign take_no_action = r_take_no_action;
   assign scan_err       = r_scan_err;
   assign busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_multicore_nios2_debug_scan_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicore_nios2_debug_scan_slave
// Brief   : Scoreboarded random/directed bench for 4- and 3-channel slaves.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicore_nios2_debug_scan_slave;

   localparam int DR_W = 38;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           vs_uir = 1'b0, vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0;
   logic [1:0]     ir_in = '0, status_in = '0;
   logic           tdi = 1'b0;
   logic [151:0]   cap_data = '0;

   logic           tdo4, tdo3, err4, err3, busy4, busy3;
   logic [1:0]     ir_out4, ir_out3;
   logic [37:0]    jdo4, jdo3;
   logic [3:0]     ta4, tna4;
   logic [2:0]     ta3, tna3;

   always #5 clk = ~clk;

   multicore_nios2_debug_scan_slave #(.IR_W(2), .N_CH(4), .DR_W(DR_W), .ACT_BIT(35)) dut4 (
      .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
      .vs_udr(vs_udr), .ir_in(ir_in), .tdi(tdi), .status_in(status_in),
      .cap_data(cap_data), .tdo(tdo4), .ir_out(ir_out4), .jdo(jdo4),
      .take_action(ta4), .take_no_action(tna4), .scan_err(err4), .busy(busy4));

   multicore_nios2_debug_scan_slave #(.IR_W(2), .N_CH(3), .DR_W(DR_W), .ACT_BIT(35)) dut3 (
      .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
      .vs_udr(vs_udr), .ir_in(ir_in), .tdi(tdi), .status_in(status_in),
      .cap_data(cap_data[3*DR_W-1:0]), .tdo(tdo3), .ir_out(ir_out3), .jdo(jdo3),
      .take_action(ta3), .take_no_action(tna3), .scan_err(err3), .busy(busy3));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [37:0] jdo;
      logic [3:0]  ta;
      logic [3:0]  tna;
   } exp_t;
   exp_t q[$];

   // Reference state: selected channel, captured words, tdi bits since capture.
   logic [1:0]  m_ir = '0;
   logic [37:0] m_cap4 = '0, m_cap3 = '0, m_jdo = '0;
   logic        m_tq[$];
   int          m_st = 0;
   logic        m_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: any pulse or jdo movement must match the oldest expectation.
   initial begin
      logic [37:0] last;
      exp_t        e;
      last = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            last = '0;
         end else if ((ta4 | tna4) != 4'b0 || jdo4 !== last) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_update: jdo=%h ta=%b tna=%b with no update pending", jdo4, ta4, tna4);
            end else begin
               e = q.pop_front();
               chk("sb_jdo", 64'(jdo4), 64'(e.jdo));
               chk("sb_take_action", 64'(ta4), 64'(e.ta));
               chk("sb_take_no_action", 64'(tna4), 64'(e.tna));
            end
            last = jdo4;
         end
      end
   end

   function automatic logic exp_tdo(input int k, input bit nch3);
      if (k < DR_W) return nch3 ? m_cap3[k] : m_cap4[k];
      return m_tq[k-DR_W];
   endfunction

   task automatic do_uir(input logic [1:0] ir, input logic [1:0] st);
      @(negedge clk);
      ir_in = ir; status_in = st; vs_uir = 1'b1;
      @(negedge clk);
      vs_uir = 1'b0;
      m_ir = ir; m_st = 0;
      if (ir == 2'b11) m_err = 1'b0;
      chk("ir_out", 64'(ir_out4), 64'(st));
      chk("ir_out_nch3", 64'(ir_out3), 64'(st));
      chk("busy_after_uir", 64'(busy4), 64'(0));
      chk("scan_err_after_uir", 64'({err4, err3}), 64'({m_err, m_err}));
   endtask

   task automatic do_cdr();
      @(negedge clk);
      vs_cdr = 1'b1;
      @(negedge clk);
      vs_cdr = 1'b0;
      m_cap4 = cap_data[int'(m_ir)*DR_W +: DR_W];
      m_cap3 = (m_ir < 2'd3) ? m_cap4 : '0;
      m_tq.delete();
      m_st = 1;
      chk("busy_captured", 64'({busy4, busy3}), 64'(2'b11));
   endtask

   task automatic do_shift(input int n, input logic [37:0] w);
      logic b;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("tdo", 64'(tdo4), 64'(exp_tdo(m_tq.size(), 1'b0)));
         chk("tdo_nch3", 64'(tdo3), 64'(exp_tdo(m_tq.size(), 1'b1)));
         b = (k < DR_W) ? w[k] : 1'($urandom_range(1, 0));
         tdi = b; vs_sdr = 1'b1;
         @(negedge clk);
         vs_sdr = 1'b0;
         m_tq.push_back(b);
         m_st = 2;
      end
   endtask

   task automatic do_udr(input bit with_cdr);
      logic [37:0] word;
      logic [3:0]  oh;
      exp_t        e;
      bit          good;
      word = '0;
      good = (m_st == 2) && (m_tq.size() == DR_W);
      oh   = 4'b0001 << m_ir;
      if (good) begin
         for (int k = 0; k < DR_W; k++) word[k] = m_tq[k];
         e.jdo = word;
         e.ta  = word[35] ? oh : 4'b0;
         e.tna = word[35] ? 4'b0 : oh;
         q.push_back(e);
      end
      @(negedge clk);
      vs_udr = 1'b1; vs_cdr = with_cdr;
      @(negedge clk);
      vs_udr = 1'b0; vs_cdr = 1'b0;
      if (good) begin
         m_jdo = word;
         chk("take_action_nch3", 64'(ta3), 64'((m_ir < 2'd3 && word[35]) ? oh[2:0] : 3'b0));
         chk("take_no_action_nch3", 64'(tna3), 64'((m_ir < 2'd3 && !word[35]) ? oh[2:0] : 3'b0));
      end else begin
         m_err = 1'b1;
         chk("no_pulse_nch3", 64'({ta3, tna3}), 64'(0));
      end
      m_st = 0;
      chk("jdo_nch3", 64'(jdo3), 64'(m_jdo));
      chk("scan_err", 64'(err4), 64'(m_err));
      chk("scan_err_nch3", 64'(err3), 64'(m_err));
      chk("busy_after_udr", 64'(busy4), 64'(0));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_jdo"}, 64'(jdo4), 64'(0));
      chk({tag, "_pulses"}, 64'({ta4, tna4, ta3, tna3}), 64'(0));
      chk({tag, "_ir_out"}, 64'({ir_out4, ir_out3}), 64'(0));
      chk({tag, "_err_busy_tdo"}, 64'({err4, err3, busy4, busy3, tdo4, tdo3}), 64'(0));
   endtask

   initial begin
      logic [159:0] r160;
      logic [63:0]  r64;
      int           n, sel;

      @(negedge clk);
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // Good scan with take_action, then the no-action variant.
      do_uir(2'd1, 2'd2);
      cap_data = '0;
      cap_data[DR_W +: DR_W] = 38'h2A_5555_AAAA;
      do_cdr();
      do_shift(38, 38'h08_0000_0001);
      do_udr(1'b0);
      do_cdr();
      do_shift(38, 38'h00_0000_0001);
      do_udr(1'b0);

      // Short and long scans.
      do_cdr();
      do_shift(37, 38'h15_0F0F_3C3C);
      do_udr(1'b0);
      do_cdr();
      do_shift(40, 38'h2B_1357_9BDF);
      do_udr(1'b0);

      // Update/capture collision, then abort by uir mid-shift.
      do_uir(2'd1, 2'd1);
      do_cdr();
      do_shift(38, 38'h3F_DEAD_BEEF);
      do_udr(1'b1);
      do_cdr();
      do_shift(10, 38'h00_1111_2222);
      do_uir(2'd1, 2'd3);
      do_udr(1'b0);

      // Asynchronous reset mid-scan, followed by a clean scan.
      do_uir(2'd1, 2'd0);
      do_cdr();
      do_shift(20, 38'h12_3456_789A);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      m_ir = '0; m_err = 1'b0; m_jdo = '0; m_st = 0;
      do_uir(2'd1, 2'd2);
      do_cdr();
      do_shift(38, 38'h08_0000_0001);
      do_udr(1'b0);

      // Channel 3: absent on the 3-channel slave, present on the 4-channel one.
      do_uir(2'd3, 2'd1);
      cap_data[3*DR_W +: DR_W] = 38'h1C_CAFE_F00D;
      do_cdr();
      do_shift(38, 38'h0B_1234_5678);
      do_udr(1'b0);
      do_udr(1'b0);
      do_uir(2'd3, 2'd0);

      // Randomised scans of mixed length on random channels.
      for (int it = 0; it < 30; it++) begin
         do_uir(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)));
         r160 = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cap_data = r160[151:0];
         do_cdr();
         sel = $urandom_range(3, 0);
         n = (sel == 0) ? 30 + $urandom_range(7, 0) : (sel == 1) ? 39 + $urandom_range(1, 0) : 38;
         r64 = {$urandom, $urandom};
         do_shift(n, r64[37:0]);
         do_udr(1'($urandom_range(1, 0)));
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
